bcd_feeder: RTL and testbench
=============================

BCD_FEEDER -- requirements
Module: bcd_feeder

Interface
REQ-001 SHALL have parameter BASE, default 'h20, meaning slave register base word address.
REQ-002 SHALL have parameter SEG_BASE, default 'h10, meaning word address of the downstream 7-segment driver's digit register; its DP register is SEG_BASE+1.
REQ-003 SHALL have parameter NDIGITS, default 4, meaning the number of BCD digits produced; MAXVAL = 10^NDIGITS-1 is derived from it.
REQ-004 SHALL have parameter VBITS, default 16, meaning the width of the binary value accepted.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port reset_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: slave bus strobe.
REQ-008 SHALL have port rw, input, 1 bit: 1 means write, 0 means read.
REQ-009 SHALL have port addr, input, 32 bits: slave word address.
REQ-010 SHALL have port data_in, input, 32 bits: slave write data.
REQ-011 SHALL have port data_out, output, 32 bits: slave read data.
REQ-012 SHALL have port m_enable, output, 1 bit: master write strobe to the display.
REQ-013 SHALL have port m_rw, output, 1 bit: master rw; it is 1 whenever m_enable is 1.
REQ-014 SHALL have port m_addr, output, 32 bits: master address.
REQ-015 SHALL have port m_data, output, 32 bits: master data.

Function
REQ-016 SHALL decode slave registers as follows:
- BASE+0 VALUE: write starts a conversion; read returns the last accepted value.
- BASE+1 STATUS: read-only; bit0 busy, bit1 overflow, bit2 pending.
- BASE+2 DP: write sets the decimal-point mask [NDIGITS-1:0]; read returns the mask.
REQ-017 SHALL return reads combinationally (same cycle) when enable&&!rw&&in range, and SHALL drive data_out=0 otherwise; unused bits read 0.
REQ-018 SHALL ignore writes outside BASE..BASE+2 and writes to STATUS.
REQ-019 SHALL use a state machine with states IDLE, CHECK, SHIFT, WRVAL and WRDP.
REQ-020 SHALL, in IDLE, on a VALUE write (or with pending value set), latch v=data_in[VBITS-1:0] into the shift register, clear the BCD accumulator and go to CHECK next cycle.
REQ-021 SHALL, in CHECK, behave as follows:
- v>MAXVAL: set overflow=1, load the BCD result with all nibbles 4'hE, go to WRVAL.
- otherwise: clear overflow, go to SHIFT with count=VBITS.
REQ-022 SHALL, in SHIFT, run one double-dabble step per cycle: add 3 to each nibble >=5, then shift {bcd,bin} left 1; after VBITS steps go to WRVAL.
REQ-023 SHALL, in WRVAL, assert m_enable=1, m_rw=1, m_addr=SEG_BASE, m_data={zero-extend, bcd[4*NDIGITS-1:0]} for exactly one cycle.
REQ-024 SHALL, after WRVAL, go to WRDP if dp pending is set, else to IDLE.
REQ-025 SHALL, in WRDP, assert m_enable=1, m_rw=1, m_addr=SEG_BASE+1, m_data=zero-extended dp mask for one cycle, clear dp pending, then go to IDLE.
REQ-026 SHALL give the fixed latency from a VALUE write to the display write: 1+1+VBITS cycles (18 at default) when in range, and 2 cycles when overflowed.
REQ-027 SHALL assert busy whenever the state is not IDLE.
REQ-028 SHALL handle a VALUE write while busy as follows: store the value in a single-depth pending register and set pending; a later write overwrites it (last wins); the in-flight conversion is not disturbed.
REQ-029 SHALL give IDLE this priority order: pending value, then VALUE write in the same cycle, then dp pending (go to WRDP directly).
REQ-030 SHALL handle a DP write in any state by updating the mask and setting dp pending; if the write coincides with the WRDP cycle, the new mask is still sent on a later WRDP.
REQ-031 SHALL handle a VALUE write arriving in IDLE while a pending value is set by replacing the pending value, and SHALL start a conversion with the replaced value.
REQ-032 SHALL hold m_enable=0, m_addr=0 and m_data=0 outside WRVAL/WRDP.

Reset
REQ-033 SHALL, when reset_n=0 at a clk edge, reset the following: state IDLE; the VALUE, pending, dp and BCD registers to 0; the flags busy, overflow, pending and dp pending to 0; m_* outputs to 0.
REQ-034 SHALL, on reset mid-conversion, abort the conversion and issue no master write.
REQ-035 SHALL issue no master write after reset until a slave write occurs.

Verification
REQ-036 SHALL be covered by a bench scenario: write VALUE=1234 -> exactly 18 cycles later, one cycle with m_addr='h10, m_data='h1234; STATUS busy=1 in between.
REQ-037 SHALL be covered by a bench scenario: write VALUE=10000 -> 2 cycles later m_data='hEEEE; STATUS reads 'b010.
REQ-038 SHALL be covered by a bench scenario: write 42, then during SHIFT write 7 and then 99 -> first m_data='h0042, then one conversion producing 'h0099; 7 is never sent.
REQ-039 SHALL be covered by a bench scenario: write DP='b0100 while idle -> next cycle go to WRDP; m_addr='h11, m_data='h4, one cycle.
REQ-040 SHALL be covered by a bench scenario: write 9999 and DP='b1000 in consecutive cycles -> WRVAL 'h9999 immediately followed by WRDP 'h8.
REQ-041 SHALL be covered by a bench scenario: reset_n=0 for one cycle during SHIFT -> no m_enable pulse; STATUS reads 0; a VALUE readback returns 0.

Source files
------------

// File: rtl/bcd_feeder.sv
// Memory-mapped binary-to-BCD converter that pushes results to a 7-segment driver.
// It converts serially with double dabble and issues single-cycle master writes.
module bcd_feeder #(
    parameter int BASE     = 'h20,
    parameter int SEG_BASE = 'h10,
    parameter int NDIGITS  = 4,
    parameter int VBITS    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        m_enable,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_data
);

    localparam int          BW     = 4 * NDIGITS;
    localparam int          CW     = $clog2(VBITS + 1);
    localparam logic [63:0] MAXVAL = 64'(10 ** NDIGITS) - 64'd1;

    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, WRVAL, WRDP} state_t;

    state_t               state_q;
    logic [VBITS-1:0]     value_q;
    logic [VBITS-1:0]     pend_val_q;
    logic                 pend_q;
    logic [NDIGITS-1:0]   dp_q;
    logic                 dp_pend_q;
    logic                 ovf_q;
    logic [BW-1:0]        bcd_q;
    logic [VBITS-1:0]     bin_q;
    logic [CW-1:0]        cnt_q;
    logic                 m_enable_q;
    logic                 m_rw_q;
    logic [31:0]          m_addr_q;
    logic [31:0]          m_data_q;

    logic                 sel_val_s, sel_st_s, sel_dp_s;
    logic                 val_wr_s, dp_wr_s;
    logic                 dp_pend_eff_s;
    logic [NDIGITS-1:0]   dp_mask_eff_s;
    logic                 busy_s;
    logic [BW-1:0]        bcd_adj_s;
    logic [BW-1:0]        bcd_d;
    logic [VBITS-1:0]     bin_d;

    // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] bcd);
        logic [BW-1:0] res;
        res = bcd;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Slave address decode; a DP write in the current cycle counts as pending immediately.
    always_comb begin
        sel_val_s     = (addr == 32'(BASE));
        sel_st_s      = (addr == 32'(BASE + 1));
        sel_dp_s      = (addr == 32'(BASE + 2));
        val_wr_s      = enable && rw && sel_val_s;
        dp_wr_s       = enable && rw && sel_dp_s;
        dp_pend_eff_s = dp_pend_q || dp_wr_s;
        dp_mask_eff_s = dp_wr_s ? data_in[NDIGITS-1:0] : dp_q;
        busy_s        = (state_q != IDLE);
    end

    // One double-dabble step on the {bcd, bin} pair.
    always_comb begin
        bcd_adj_s = dabble_adjust(bcd_q);
        bcd_d     = {bcd_adj_s[BW-2:0], bin_q[VBITS-1]};
        bin_d     = {bin_q[VBITS-2:0], 1'b0};
    end

    // Combinational slave read mux.
    always_comb begin
        data_out = 32'd0;
        if (enable && !rw) begin
            if (sel_val_s) begin
                data_out = 32'(value_q);
            end else if (sel_st_s) begin
                data_out = {29'd0, pend_q, ovf_q, busy_s};
            end else if (sel_dp_s) begin
                data_out = 32'(dp_q);
            end else begin
                data_out = 32'd0;
            end
        end else begin
            data_out = 32'd0;
        end
    end

    // Conversion FSM; master outputs are loaded on entry to WRVAL/WRDP so they are registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            value_q    <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            dp_q       <= '0;
            dp_pend_q  <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            m_enable_q <= 1'b0;
            m_rw_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_data_q   <= 32'd0;
        end else begin
            m_enable_q <= 1'b0;
            m_rw_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_data_q   <= 32'd0;
            if (val_wr_s) begin
                value_q <= data_in[VBITS-1:0];
            end
            if (dp_wr_s) begin
                dp_q      <= data_in[NDIGITS-1:0];
                dp_pend_q <= 1'b1;
            end
            if (val_wr_s && busy_s) begin
                pend_val_q <= data_in[VBITS-1:0];
                pend_q     <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (pend_q || val_wr_s) begin
                        bin_q   <= val_wr_s ? data_in[VBITS-1:0] : pend_val_q;
                        bcd_q   <= '0;
                        pend_q  <= 1'b0;
                        state_q <= CHECK;
                    end else if (dp_pend_eff_s) begin
                        m_enable_q <= 1'b1;
                        m_rw_q     <= 1'b1;
                        m_addr_q   <= 32'(SEG_BASE + 1);
                        m_data_q   <= 32'(dp_mask_eff_s);
                        state_q    <= WRDP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHECK: begin
                    if (64'(bin_q) > MAXVAL) begin
                        ovf_q      <= 1'b1;
                        bcd_q      <= {NDIGITS{4'hE}};
                        m_enable_q <= 1'b1;
                        m_rw_q     <= 1'b1;
                        m_addr_q   <= 32'(SEG_BASE);
                        m_data_q   <= 32'({NDIGITS{4'hE}});
                        state_q    <= WRVAL;
                    end else begin
                        ovf_q   <= 1'b0;
                        cnt_q   <= CW'(VBITS);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        m_enable_q <= 1'b1;
                        m_rw_q     <= 1'b1;
                        m_addr_q   <= 32'(SEG_BASE);
                        m_data_q   <= 32'(bcd_d);
                        state_q    <= WRVAL;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                WRVAL: begin
                    if (dp_pend_eff_s) begin
                        m_enable_q <= 1'b1;
                        m_rw_q     <= 1'b1;
                        m_addr_q   <= 32'(SEG_BASE + 1);
                        m_data_q   <= 32'(dp_mask_eff_s);
                        state_q    <= WRDP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRDP: begin
                    // A DP write landing in this cycle keeps pending so the new mask goes out later.
                    if (!dp_wr_s) begin
                        dp_pend_q <= 1'b0;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_enable = m_enable_q;
    assign m_rw     = m_rw_q;
    assign m_addr   = m_addr_q;
    assign m_data   = m_data_q;

endmodule

// File: tb/tb_bcd_feeder.sv
// Directed bench for bcd_feeder: slave register access, conversion latency,
// overflow, pending-value/last-wins, DP writes and mid-conversion reset.
module tb_bcd_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        m_enable;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses = 0;

    localparam logic [31:0] A_VAL = 32'h20;
    localparam logic [31:0] A_ST  = 32'h21;
    localparam logic [31:0] A_DP  = 32'h22;

    bcd_feeder dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(data_out), .m_enable(m_enable), .m_rw(m_rw),
        .m_addr(m_addr), .m_data(m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (m_enable) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; rw = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        enable = 1'b0; rw = 1'b0; addr = 32'd0; data_in = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        enable = 1'b1; rw = 1'b0; addr = a;
        #1;
        d = data_out;
        enable = 1'b0; addr = 32'd0;
    endtask

    task automatic wait_pulse(input string tag, input int t0, input int exp_lat,
                              input logic [31:0] exp_addr, input logic [31:0] exp_data);
        int lat;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_enable) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        lat = found ? (cyc - t0 + 1) : -1;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_addr"}, m_addr, exp_addr);
        chk({tag, "_data"}, m_data, exp_data);
        chk({tag, "_rw"}, {31'd0, m_rw}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int t0;
        int p0;

        // Reset state
        step(3);
        chk("rst_m_enable", {31'd0, m_enable}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        reset_n = 1'b1;
        step(1);
        rd(A_ST, r);  chk("rst_status", r, 32'd0);
        rd(A_VAL, r); chk("rst_value", r, 32'd0);

        // 1234 -> 0x1234 after 18 cycles, busy in between
        wr(A_VAL, 32'd1234); t0 = cyc;
        rd(A_ST, r); chk("s1_busy", r, 32'b001);
        step(8);
        rd(A_ST, r); chk("s1_busy_mid", r, 32'b001);
        wait_pulse("s1", t0, 18, 32'h10, 32'h1234);
        step(1);
        chk("s1_one_cycle", {31'd0, m_enable}, 32'd0);
        rd(A_VAL, r); chk("s1_readback", r, 32'd1234);

        // Writes to STATUS and out of range are ignored; out of range reads are 0
        p0 = pulses;
        wr(A_ST, 32'hFFFF);
        wr(32'h23, 32'd5);
        step(4);
        rd(A_ST, r);         chk("ign_status", r, 32'd0);
        rd(32'h23, r);       chk("ign_oor_read", r, 32'd0);
        chk("ign_no_pulse", 32'(pulses - p0), 32'd0);
        enable = 1'b0; rw = 1'b0; addr = A_VAL; #1;
        chk("noenable_read", data_out, 32'd0);
        addr = 32'd0;

        // Zero converts to 0x0000
        wr(A_VAL, 32'd0); t0 = cyc;
        wait_pulse("s0", t0, 18, 32'h10, 32'h0000);
        step(1);

        // 10000 overflows: EEEE after 2 cycles, STATUS b010
        wr(A_VAL, 32'd10000); t0 = cyc;
        wait_pulse("ovf", t0, 2, 32'h10, 32'hEEEE);
        step(1);
        rd(A_ST, r); chk("ovf_status", r, 32'b010);

        // 42, then 7 and 99 while busy: only 42 and 99 are sent
        p0 = pulses;
        wr(A_VAL, 32'd42); t0 = cyc;
        step(2);
        wr(A_VAL, 32'd7);
        rd(A_ST, r); chk("s3_pending", r, 32'b101);
        wr(A_VAL, 32'd99);
        wait_pulse("s3a", t0, 18, 32'h10, 32'h0042);
        step(1);
        t0 = cyc;
        wait_pulse("s3b", t0, 19, 32'h10, 32'h0099);
        step(25);
        chk("s3_pulse_count", 32'(pulses - p0), 32'd2);
        rd(A_ST, r);  chk("s3_status_clear", r, 32'd0);
        rd(A_VAL, r); chk("s3_readback", r, 32'd99);

        // DP write while idle -> WRDP next cycle
        wr(A_DP, 32'b0100); t0 = cyc;
        wait_pulse("dp", t0, 1, 32'h11, 32'h4);
        step(1);
        chk("dp_one_cycle", {31'd0, m_enable}, 32'd0);
        rd(A_DP, r); chk("dp_readback", r, 32'h4);

        // 9999 then DP in consecutive cycles -> WRVAL then WRDP back to back
        wr(A_VAL, 32'd9999); t0 = cyc;
        wr(A_DP, 32'b1000);
        wait_pulse("s5v", t0, 18, 32'h10, 32'h9999);
        step(1);
        chk("s5d_en", {31'd0, m_enable}, 32'd1);
        chk("s5d_addr", m_addr, 32'h11);
        chk("s5d_data", m_data, 32'h8);
        step(1);
        chk("s5_end", {31'd0, m_enable}, 32'd0);
        chk("s5_end_addr", m_addr, 32'd0);

        // Reset during SHIFT aborts with no master write
        wr(A_VAL, 32'd1234);
        step(5);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        p0 = pulses;
        step(25);
        chk("rst_mid_no_pulse", 32'(pulses - p0), 32'd0);
        rd(A_ST, r);  chk("rst_mid_status", r, 32'd0);
        rd(A_VAL, r); chk("rst_mid_value", r, 32'd0);
        rd(A_DP, r);  chk("rst_mid_dp", r, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
